mem_port_arbiter: RTL

- Shares one memory bus between the instruction-fetch port (port I) and the data/storebuffer port (port D).
- Each port has a one-entry pending register, because requesters pulse valid for one cycle.
- The block issues one outstanding memory transaction at a time and returns the response to the owning port.
- Sits between the fetch/storebuffer stages and the memory bus; services data-port fences locally.

---
 rtl/mem_port_arbiter_pkg.sv | 30 +++
 rtl/mem_port_arbiter_slot.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states and the pending
// request record held by each port slot.
package mem_port_arbiter_pkg;

  // Width of the request record; the top-level XLEN must equal this value.
  localparam int ARB_XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    FENCE
  } arb_state_type;

  typedef struct packed {
    logic                valid;
    logic                fence;
    logic                instr;
    logic [ARB_XLEN-1:0] addr;
    logic [ARB_XLEN-1:0] wdata;
    logic [3:0]          wstrb;
  } arb_req_type;

  function automatic arb_req_type init_arb_req();
    arb_req_type r;
    r = '0;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_slot.sv
// One-entry pending register for a requester that pulses valid for a cycle.
// Presents either the held entry or the request arriving this cycle.
module arb_req_slot
  import mem_port_arbiter_pkg::*;
#(
  parameter bit INSTR = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_fence,
  input  logic [ARB_XLEN-1:0] req_addr,
  input  logic [ARB_XLEN-1:0] req_wdata,
  input  logic [3:0]          req_wstrb,
  input  logic                clear,
  output arb_req_type         entry,
  output logic                violation
);

  arb_req_type slot_reg;
  arb_req_type incoming;
  logic        accept;

  always_comb begin
    incoming       = init_arb_req();
    incoming.valid = req_valid;
    incoming.fence = req_fence && !INSTR;
    incoming.instr = INSTR;
    incoming.addr  = req_addr;
    incoming.wdata = req_wdata;
    incoming.wstrb = INSTR ? 4'b0000 : req_wstrb;
  end

  // A request landing on the clearing cycle is a legal back-to-back capture.
  assign accept    = req_valid && (!slot_reg.valid || clear);
  assign violation = req_valid && slot_reg.valid && !clear;
  assign entry     = slot_reg.valid ? slot_reg : incoming;

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_reg <= init_arb_req();
    end else if (accept) begin
      slot_reg <= incoming;
    end else if (clear) begin
      slot_reg <= init_arb_req();
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory bus between the fetch port and the
// data port, one outstanding transaction at a time; data fences complete locally.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit DPRIO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ready,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_valid,
  input  logic            d_fence,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_wstrb,
  output logic            d_ready,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_valid,
  output logic            m_instr,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  output logic [3:0]      m_wstrb,
  input  logic            m_ready,
  input  logic [XLEN-1:0] m_rdata,
  output logic            prot_err
);

  arb_state_type   state_reg, state_next;
  logic            last_d_reg, last_d_next;
  logic            prot_err_reg;
  logic            m_valid_reg, m_valid_next;
  logic            m_instr_reg, m_instr_next;
  logic [XLEN-1:0] m_addr_reg, m_addr_next;
  logic [XLEN-1:0] m_wdata_reg, m_wdata_next;
  logic [3:0]      m_wstrb_reg, m_wstrb_next;

  arb_req_type i_entry, d_entry, grant;
  logic        i_viol, d_viol;
  logic        clear_i, clear_d;
  logic        grant_d;

  arb_req_slot #(.INSTR(1'b1)) u_slot_i (
    .clk       (clk),
    .rst       (rst),
    .req_valid (i_valid),
    .req_fence (1'b0),
    .req_addr  (i_addr),
    .req_wdata ('0),
    .req_wstrb (4'b0000),
    .clear     (clear_i),
    .entry     (i_entry),
    .violation (i_viol)
  );

  arb_req_slot #(.INSTR(1'b0)) u_slot_d (
    .clk       (clk),
    .rst       (rst),
    .req_valid (d_valid),
    .req_fence (d_fence),
    .req_addr  (d_addr),
    .req_wdata (d_wdata),
    .req_wstrb (d_wstrb),
    .clear     (clear_d),
    .entry     (d_entry),
    .violation (d_viol)
  );

  always_comb begin
    state_next   = state_reg;
    last_d_next  = last_d_reg;
    clear_i      = 1'b0;
    clear_d      = 1'b0;
    grant_d      = 1'b0;
    grant        = init_arb_req();
    m_valid_next = 1'b0;
    m_instr_next = m_instr_reg;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;
    m_wstrb_next = m_wstrb_reg;
    case (state_reg)
      IDLE: begin
        // D wins when I is idle, or on contention when I went last.
        grant_d = d_entry.valid && (!i_entry.valid || !last_d_reg);
        grant   = grant_d ? d_entry : i_entry;
        if (grant.valid) begin
          if (grant.fence) begin
            state_next = FENCE;
          end else begin
            m_valid_next = 1'b1;
            m_instr_next = grant.instr;
            m_addr_next  = grant.addr;
            m_wdata_next = grant.wdata;
            m_wstrb_next = grant.wstrb;
            state_next   = grant_d ? BUSY_D : BUSY_I;
          end
        end
      end
      BUSY_I: begin
        if (m_ready) begin
          clear_i     = 1'b1;
          last_d_next = 1'b0;
          state_next  = IDLE;
        end
      end
      BUSY_D: begin
        if (m_ready) begin
          clear_d     = 1'b1;
          last_d_next = 1'b1;
          state_next  = IDLE;
        end
      end
      FENCE: begin
        clear_d     = 1'b1;
        last_d_next = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      last_d_reg   <= ~DPRIO;
      prot_err_reg <= 1'b0;
      m_valid_reg  <= 1'b0;
      m_instr_reg  <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      m_wstrb_reg  <= 4'b0000;
    end else begin
      state_reg    <= state_next;
      last_d_reg   <= last_d_next;
      prot_err_reg <= prot_err_reg | i_viol | d_viol;
      m_valid_reg  <= m_valid_next;
      m_instr_reg  <= m_instr_next;
      m_addr_reg   <= m_addr_next;
      m_wdata_reg  <= m_wdata_next;
      m_wstrb_reg  <= m_wstrb_next;
    end
  end

  // Responses are a same-cycle pass-through of the memory strobe.
  assign i_ready  = (state_reg == BUSY_I) && m_ready;
  assign i_rdata  = i_ready ? m_rdata : '0;
  assign d_ready  = ((state_reg == BUSY_D) && m_ready) || (state_reg == FENCE);
  assign d_rdata  = ((state_reg == BUSY_D) && m_ready) ? m_rdata : '0;
  assign m_valid  = m_valid_reg;
  assign m_instr  = m_instr_reg;
  assign m_addr   = m_addr_reg;
  assign m_wdata  = m_wdata_reg;
  assign m_wstrb  = m_wstrb_reg;
  assign prot_err = prot_err_reg;

endmodule
